lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Hardware HD44780-style character-LCD driver: the consuming end of the LCD I/O write path from the load/store unit.
- Replaces software bit-banging of EN/RS/RW via the LCD I/O register.
- Accepts one command or data byte per handshake and generates the pin sequence: setup, enable pulse, hold, then a busy-wait.
- Sits between the LSU's LCD register decode and the board LCD pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000, core clock frequency; sets the microsecond-to-cycle conversion.
- SETUP_CYC, 4, cycles RS/DATA are stable before EN rises (≥1).
- EN_CYC, 12, cycles EN is held high (≥1).
- HOLD_CYC, 4, cycles RS/DATA are held after EN falls (≥1).
- SHORT_WAIT_US, 40, execution wait for normal commands and data writes.
- LONG_WAIT_US, 1640, execution wait for clear/home commands.

Ports:
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous reset, active-low.
- i_valid  in  1  request strobe from the LSU LCD write.
- o_ready  out  1  high when a new byte can be accepted.
- i_rs  in  1  0 = command, 1 = data.
- i_data  in  8  byte to write.
- i_lcd_on  in  1  backlight/power request.
- o_lcd_data  out  8  LCD DB[7:0].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD R/W, always 0 (write-only).
- o_lcd_en  out  1  LCD E.
- o_lcd_on  out  1  LCD power; registered copy of i_lcd_on.
- o_busy  out  1  inverse of o_ready.

Behaviour:
- Reset (i_reset = 0 at a rising edge):
  - o_lcd_data = 0, o_lcd_rs = 0, o_lcd_rw = 0, o_lcd_en = 0, o_lcd_on = 0.
  - State = IDLE, with o_ready = 1 and o_busy = 0 (unless LCD_INIT_EN is defined).
  - Reset mid-transfer aborts immediately; EN drops the same edge.
- Handshake:
  - A transfer is accepted on an edge where i_valid && o_ready; i_rs and i_data are latched to the outputs on that edge.
  - o_ready is high only in IDLE.
  - i_valid while busy is ignored; no queueing.
  - i_valid may stay high: back-to-back requests are accepted on the first IDLE cycle.
- FSM states: IDLE → SETUP → PULSE → HOLD → WAIT → IDLE.
  - SETUP lasts SETUP_CYC cycles, EN = 0.
  - PULSE lasts EN_CYC cycles, EN = 1.
  - HOLD lasts HOLD_CYC cycles, EN = 0.
  - WAIT lasts W cycles, EN = 0.
  - Accept at edge k: EN is high exactly in cycles k+1+SETUP_CYC through k+SETUP_CYC+EN_CYC.
  - o_ready returns high in cycle k+1+SETUP_CYC+EN_CYC+HOLD_CYC+W.
- Wait selection:
  - W = LONG_WAIT_US × (CLK_FREQ_HZ / 1_000_000) when i_rs = 0 and i_data[7:2] = 0 (clear 0x01, home 0x02/0x03).
  - Otherwise W = SHORT_WAIT_US × (CLK_FREQ_HZ / 1_000_000).
- Timer:
  - A single down-counter, width $clog2 of the largest cycle count + 1.
  - Each phase loads count−1 and advances on zero; no wrap.
- Output stability: o_lcd_data and o_lcd_rs are held from accept until the next accept; they do not change during SETUP through WAIT.
- i_lcd_on: registered every cycle, independent of the FSM.

Optional Feature:
- Macro: LCD_INIT_EN.
- When defined, after reset the FSM enters INIT_PWR.
  - INIT_PWR waits 15000 µs (scaled by CLK_FREQ_HZ).
  - The block then issues the internal sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (all RS = 0) through SETUP/PULSE/HOLD/WAIT with the same wait rules.
  - It then enters IDLE.
  - o_ready stays 0 throughout initialisation, and external i_valid is ignored.
- When undefined, the INIT states and ROM are absent and reset goes directly to IDLE.

Decomposition:
- Package lcd_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, WAIT, INIT_PWR);
  - the init ROM constants and their length (6);
  - the localparam helper for the µs-to-cycle conversion.
- Sub-module lcd_timer: a loadable down-counter with a zero flag, shared by all phases.

Test Plan (CLK_FREQ_HZ = 1_000_000, SETUP_CYC = 2, EN_CYC = 3, HOLD_CYC = 2, SHORT = 40, LONG = 1640):
- Reset low 3 cycles, then high → all outputs 0 and o_ready = 1 (LCD_INIT_EN undefined).
- Write rs=1, data=0x41 → data/rs valid next cycle; EN high exactly cycles 3–5 after accept; o_ready returns 48 cycles after accept.
- Write command 0x01 → EN pulse of 3 cycles; o_ready returns 1648 cycles after accept. Repeat with 0x80 → 48 cycles.
- Hold i_valid high with 0x41 then 0x42 presented during busy → 0x42 is accepted on the first IDLE cycle and no byte is lost or duplicated; presenting 0x42 mid-transfer does not alter o_lcd_data.
- Assert reset during PULSE → o_lcd_en = 0 and o_ready = 1 on the next edge after reset is released. With LCD_INIT_EN defined → 15000-cycle wait, then 6 EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, then o_ready = 1.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780-style LCD driver.
//               Holds the FSM state encoding, the power-up initialisation
//               byte sequence and the microsecond-to-cycle helper.
//               The init constants are only used when LCD_INIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT     = 3'd4,
        ST_INIT_PWR = 3'd5
    } lcd_state_e;

    // Power-on settle time before the first init command.
    localparam int c_pwr_us = 15000;

    // Init sequence, issued from byte 0 (LSB) upwards:
    // function set x3, display on, clear, entry mode.
    localparam int c_init_len = 6;
    localparam logic [c_init_len*8-1:0] c_init_rom =
        {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        return c_init_rom[int'(idx)*8 +: 8];
    endfunction

    function automatic int us_to_cyc(input int us, input int clk_hz);
        return us * (clk_hz / 1_000_000);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timer
// Description : Loadable down-counter with zero flag, shared by every FSM
//               phase. It stops at zero and never wraps.
// Ports       : i_clk      - clock
//               i_reset    - synchronous reset, active-low (loads RST_VAL)
//               i_load     - load i_load_val this edge
//               i_load_val - value to load (phase length - 1)
//               o_zero     - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timer #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt_q;
    logic [WIDTH-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_load) begin
            w_cnt_d = i_load_val;
        end else if (r_cnt_q != '0) begin
            w_cnt_d = r_cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt_q <= RST_VAL;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_zero = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : HD44780-style character LCD write driver. Accepts one
//               command/data byte per valid/ready handshake and generates
//               setup -> EN pulse -> hold -> execution wait on the LCD pins.
//               Clear/home commands (RS=0, DB[7:2]=0) get the long wait.
//               Optional macro LCD_INIT_EN: after reset, wait 15 ms and issue
//               the power-up init sequence before the first IDLE.
// Ports       : i_clk, i_reset (sync, active-low)
//               i_valid/o_ready/o_busy - request handshake
//               i_rs, i_data           - byte to write
//               i_lcd_on               - LCD power request
//               o_lcd_data/rs/rw/en/on - LCD pins
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int SETUP_CYC     = 4,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 4,
    parameter int SHORT_WAIT_US = 40,
    parameter int LONG_WAIT_US  = 1640
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_lcd_on,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_busy
);

    localparam int c_short_cyc = us_to_cyc(SHORT_WAIT_US, CLK_FREQ_HZ);
    localparam int c_long_cyc  = us_to_cyc(LONG_WAIT_US, CLK_FREQ_HZ);
`ifdef LCD_INIT_EN
    localparam int c_pwr_cyc   = us_to_cyc(c_pwr_us, CLK_FREQ_HZ);
`else
    localparam int c_pwr_cyc   = 1;
`endif
    localparam int c_max_cyc   = max_int(max_int(max_int(SETUP_CYC, EN_CYC),
                                                 max_int(HOLD_CYC, c_long_cyc)),
                                         max_int(c_short_cyc, c_pwr_cyc));
    localparam int c_tw        = $clog2(c_max_cyc + 1);

    localparam logic [c_tw-1:0] c_setup_ld = c_tw'(SETUP_CYC - 1);
    localparam logic [c_tw-1:0] c_en_ld    = c_tw'(EN_CYC - 1);
    localparam logic [c_tw-1:0] c_hold_ld  = c_tw'(HOLD_CYC - 1);
    localparam logic [c_tw-1:0] c_short_ld = c_tw'(c_short_cyc - 1);
    localparam logic [c_tw-1:0] c_long_ld  = c_tw'(c_long_cyc - 1);
`ifdef LCD_INIT_EN
    localparam lcd_state_e      c_rst_state = ST_INIT_PWR;
    localparam logic [c_tw-1:0] c_tmr_rst   = c_tw'(c_pwr_cyc - 1);
    localparam logic [2:0]      c_idx_len   = 3'(c_init_len);
`else
    localparam lcd_state_e      c_rst_state = ST_IDLE;
    localparam logic [c_tw-1:0] c_tmr_rst   = '0;
`endif

    lcd_state_e      r_state_q, w_state_d;
    logic [7:0]      r_lcd_data_q, w_lcd_data_d;
    logic            r_lcd_rs_q, w_lcd_rs_d;
    logic            r_lcd_en_q, w_lcd_en_d;
    logic            r_lcd_on_q;
    logic            w_ready;
    logic            w_is_long;
    logic            w_tmr_load;
    logic [c_tw-1:0] w_tmr_val;
    logic            w_tmr_zero;
`ifdef LCD_INIT_EN
    logic [2:0]      r_init_idx_q, w_init_idx_d;
`endif

    lcd_timer #(
        .WIDTH   (c_tw),
        .RST_VAL (c_tmr_rst)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Byte is latched on accept and stable through WAIT, so the wait length
    // can be decided from the registered copy.
    assign w_is_long = !r_lcd_rs_q && (r_lcd_data_q[7:2] == 6'd0);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state_q    <= c_rst_state;
            r_lcd_data_q <= 8'h00;
            r_lcd_rs_q   <= 1'b0;
            r_lcd_en_q   <= 1'b0;
            r_lcd_on_q   <= 1'b0;
`ifdef LCD_INIT_EN
            r_init_idx_q <= 3'd0;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_lcd_data_q <= w_lcd_data_d;
            r_lcd_rs_q   <= w_lcd_rs_d;
            r_lcd_en_q   <= w_lcd_en_d;
            r_lcd_on_q   <= i_lcd_on;
`ifdef LCD_INIT_EN
            r_init_idx_q <= w_init_idx_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_d    = r_state_q;
        w_lcd_data_d = r_lcd_data_q;
        w_lcd_rs_d   = r_lcd_rs_q;
        w_tmr_load   = 1'b0;
        w_tmr_val    = c_setup_ld;
`ifdef LCD_INIT_EN
        w_init_idx_d = r_init_idx_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    w_state_d    = ST_SETUP;
                    w_lcd_data_d = i_data;
                    w_lcd_rs_d   = i_rs;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_setup_ld;
                end
            end
            ST_SETUP: begin
                if (w_tmr_zero) begin
                    w_state_d  = ST_PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_en_ld;
                end
            end
            ST_PULSE: begin
                if (w_tmr_zero) begin
                    w_state_d  = ST_HOLD;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_hold_ld;
                end
            end
            ST_HOLD: begin
                if (w_tmr_zero) begin
                    w_state_d  = ST_WAIT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_is_long ? c_long_ld : c_short_ld;
                end
            end
`ifdef LCD_INIT_EN
            // Power-up wait and every init write's wait both fall through
            // to the next ROM byte until the sequence is exhausted.
            ST_WAIT, ST_INIT_PWR: begin
                if (w_tmr_zero) begin
                    if (r_init_idx_q != c_idx_len) begin
                        w_state_d    = ST_SETUP;
                        w_lcd_data_d = init_byte(r_init_idx_q);
                        w_lcd_rs_d   = 1'b0;
                        w_init_idx_d = r_init_idx_q + 3'd1;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = c_setup_ld;
                    end else begin
                        w_state_d = ST_IDLE;
                    end
                end
            end
`else
            ST_WAIT: begin
                if (w_tmr_zero) begin
                    w_state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // EN is registered from the next state so the pin is glitch-free and
    // still drops on the same edge as a reset.
    always_comb begin
        w_ready    = (r_state_q == ST_IDLE);
        w_lcd_en_d = (w_state_d == ST_PULSE);
    end

    assign o_ready    = w_ready;
    assign o_busy     = !w_ready;
    assign o_lcd_data = r_lcd_data_q;
    assign o_lcd_rs   = r_lcd_rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en_q;
    assign o_lcd_on   = r_lcd_on_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl
// Description : Self-checking bench for lcd_ctrl (default build). A cycle-
//               numbered transaction model predicts ready, EN window, pin
//               values and power output from accept times and wait rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

    localparam int c_s  = 2;
    localparam int c_e  = 3;
    localparam int c_h  = 2;
    localparam int c_ws = 40;
    localparam int c_wl = 1640;

    logic       clk;
    logic       i_reset, i_valid, i_rs, i_lcd_on;
    logic [7:0] i_data;
    logic       o_ready, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy;
    logic [7:0] o_lcd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: cycle from which ready is expected, cycle of last accept,
    // and the byte/flags the pins should show.
    int         m_free = 0;
    int         m_acc  = -1000;
    logic [7:0] m_data = 8'h00;
    logic       m_rs   = 1'b0;
    logic       m_on   = 1'b0;

    lcd_ctrl #(
        .CLK_FREQ_HZ   (1_000_000),
        .SETUP_CYC     (c_s),
        .EN_CYC        (c_e),
        .HOLD_CYC      (c_h),
        .SHORT_WAIT_US (c_ws),
        .LONG_WAIT_US  (c_wl)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs       (i_rs),
        .i_data     (i_data),
        .i_lcd_on   (i_lcd_on),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic rst, input logic v, input logic rs,
                        input logic [7:0] d, input logic on);
        int   k;
        logic exp_ready;
        logic exp_en;
        i_reset  = rst;
        i_valid  = v;
        i_rs     = rs;
        i_data   = d;
        i_lcd_on = on;
        @(posedge clk);
        k   = cyc;
        cyc = k + 1;
        if (!rst) begin
            m_free = 0;
            m_acc  = -1000;
            m_data = 8'h00;
            m_rs   = 1'b0;
            m_on   = 1'b0;
        end else begin
            m_on = on;
            if (v && k >= m_free) begin
                m_acc  = k;
                m_data = d;
                m_rs   = rs;
                m_free = k + 1 + c_s + c_e + c_h + ((!rs && d < 8'd4) ? c_wl : c_ws);
            end
        end
        @(negedge clk);
        exp_ready = (cyc >= m_free);
        exp_en    = (cyc - m_acc >= c_s + 1) && (cyc - m_acc <= c_s + c_e);
        chk("ready", 32'(o_ready), 32'(exp_ready));
        chk("busy",  32'(o_busy),  32'(!exp_ready));
        chk("en",    32'(o_lcd_en), 32'(exp_en));
        chk("data",  32'(o_lcd_data), 32'(m_data));
        chk("rs",    32'(o_lcd_rs), 32'(m_rs));
        chk("rw",    32'(o_lcd_rw), 32'h0);
        chk("on",    32'(o_lcd_on), 32'(m_on));
    endtask

    task automatic idle_until_free();
        for (int i = 0; i < 5000 && cyc < m_free; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
    endtask

    initial begin
        logic       v, rs, rst, on;
        logic [7:0] d;
        i_reset = 1'b0; i_valid = 1'b0; i_rs = 1'b0; i_data = 8'h00; i_lcd_on = 1'b0;

        // Reset, then idle with power requested.
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Data write 'A' (short wait).
        step(1'b1, 1'b1, 1'b1, 8'h41, 1'b1);
        idle_until_free();
        // Clear display (long wait), then set DDRAM address (short wait).
        step(1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
        idle_until_free();
        step(1'b1, 1'b1, 1'b0, 8'h80, 1'b1);
        idle_until_free();

        // Valid held high: 0x41 then 0x42 presented while busy.
        step(1'b1, 1'b1, 1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 200 && m_data != 8'h42; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'h42, 1'b1);
        end
        idle_until_free();

        // Reset in the middle of the EN pulse.
        step(1'b1, 1'b1, 1'b1, 8'h55, 1'b1);
        repeat (c_s + 1) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic: data changes every cycle, occasional resets
        // and clear/home commands.
        for (int n = 0; n < 6000; n++) begin
            rst = ($urandom_range(0, 799) != 0);
            v   = ($urandom_range(0, 3) != 0);
            on  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(0, 3));
            end else begin
                rs = 1'($urandom_range(0, 1));
                d  = 8'($urandom_range(0, 255));
            end
            step(rst, v, rs, d, on);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
